timer_watchdog_ctrl: RTL and testbench

//   AVMM master driving the timer_bank slave (sits directly upstream of it).

---
 rtl/timer_watchdog_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_timer_watchdog_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_watchdog_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : timer_watchdog_ctrl
//  Brief    : AVMM master in front of timer_bank. Turns per-channel arm/cancel
//             requests into writes, polls active timers, flags expiry.
//  Revision : 1.0
// ============================================================================
module timer_watchdog_ctrl #(
    parameter int NUM_CH        = 3,
    parameter int TIMER_WIDTH   = 20,
    parameter int POLL_INTERVAL = 64
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [NUM_CH-1:0]             arm,
    input  logic [NUM_CH*TIMER_WIDTH-1:0] arm_value,
    input  logic [NUM_CH-1:0]             cancel,
    output logic [NUM_CH-1:0]             active,
    output logic [NUM_CH-1:0]             expired,
    output logic [2:0]                    avmm_address,
    output logic                          avmm_read,
    output logic                          avmm_write,
    output logic [31:0]                   avmm_writedata,
    input  logic [31:0]                   avmm_readdata
);

    localparam int c_CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int c_PC_W = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
    localparam logic [c_PC_W-1:0] c_POLL_RELOAD = c_PC_W'(POLL_INTERVAL - 1);
    localparam int c_RUN_BIT = 28;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    state_t                          r_state;
    logic [NUM_CH-1:0]               r_arm_pend;
    logic [NUM_CH-1:0]               r_cancel_pend;
    logic [NUM_CH*TIMER_WIDTH-1:0]   r_val;
    logic [NUM_CH-1:0]               r_active;
    logic [NUM_CH-1:0]               r_expired;
    logic [c_PC_W-1:0]               r_poll_cnt;
    logic [c_CH_W-1:0]               r_rr;
    logic [c_CH_W-1:0]               r_ch;
    logic                            r_wr_cancel;
    logic                            r_avmm_read;
    logic                            r_avmm_write;
    logic [2:0]                      r_avmm_address;
    logic [31:0]                     r_avmm_writedata;

    logic [c_CH_W-1:0]               w_cancel_ch;
    logic [c_CH_W-1:0]               w_arm_ch;
    logic [c_CH_W-1:0]               w_poll_ch;
    logic [c_CH_W-1:0]               w_idx;
    logic [c_CH_W-1:0]               w_rr_next;
    logic [TIMER_WIDTH-1:0]          w_arm_val;
    logic [31:0]                     w_arm_wdata;
    logic                            w_rd_zero;
    logic                            w_rd_stale;
    logic                            w_unused;

    // Lowest-index pending request of each kind.
    always_comb begin
        w_cancel_ch = '0;
        w_arm_ch    = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (r_cancel_pend[i]) w_cancel_ch = c_CH_W'(i);
            if (r_arm_pend[i])    w_arm_ch    = c_CH_W'(i);
        end
    end

    always_comb begin
        w_arm_val   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_arm_ch == c_CH_W'(i)) w_arm_val = r_val[i*TIMER_WIDTH +: TIMER_WIDTH];
        end
        w_arm_wdata                    = '0;
        w_arm_wdata[TIMER_WIDTH-1:0]   = w_arm_val;
        w_arm_wdata[c_RUN_BIT]         = 1'b1;
    end

    // First active channel at or after the round-robin pointer.
    always_comb begin
        w_poll_ch = r_rr;
        w_idx     = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            w_idx = c_CH_W'((int'(r_rr) + k) % NUM_CH);
            if (r_active[w_idx]) w_poll_ch = w_idx;
        end
    end

    assign w_rr_next  = (r_ch == c_CH_W'(NUM_CH - 1)) ? '0 : r_ch + 1'b1;
    assign w_rd_zero  = (avmm_readdata[TIMER_WIDTH-1:0] == '0);
    assign w_rd_stale = r_arm_pend[r_ch] | r_cancel_pend[r_ch] | arm[r_ch] | cancel[r_ch];
    assign w_unused   = ^avmm_readdata[31:TIMER_WIDTH];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state          <= ST_IDLE;
            r_arm_pend       <= '0;
            r_cancel_pend    <= '0;
            r_val            <= '0;
            r_active         <= '0;
            r_expired        <= '0;
            r_poll_cnt       <= c_POLL_RELOAD;
            r_rr             <= '0;
            r_ch             <= '0;
            r_wr_cancel      <= 1'b0;
            r_avmm_read      <= 1'b0;
            r_avmm_write     <= 1'b0;
            r_avmm_address   <= '0;
            r_avmm_writedata <= '0;
        end else begin
            if (r_poll_cnt != '0) r_poll_cnt <= r_poll_cnt - 1'b1;
            r_avmm_read      <= 1'b0;
            r_avmm_write     <= 1'b0;
            r_avmm_address   <= '0;
            r_avmm_writedata <= '0;

            case (r_state)
                ST_IDLE: begin
                    // The served pend bit drops at selection rather than at the end
                    // of WRITE; nothing inspects it meanwhile, and a request arriving
                    // during the transaction then re-raises it instead of being lost.
                    if (|r_cancel_pend) begin
                        r_ch                       <= w_cancel_ch;
                        r_wr_cancel                <= 1'b1;
                        r_cancel_pend[w_cancel_ch] <= 1'b0;
                        r_avmm_write               <= 1'b1;
                        r_avmm_address             <= 3'(w_cancel_ch);
                        r_state                    <= ST_WRITE;
                    end else if (|r_arm_pend) begin
                        r_ch                 <= w_arm_ch;
                        r_wr_cancel          <= 1'b0;
                        r_arm_pend[w_arm_ch] <= 1'b0;
                        r_avmm_write         <= 1'b1;
                        r_avmm_address       <= 3'(w_arm_ch);
                        r_avmm_writedata     <= w_arm_wdata;
                        r_state              <= ST_WRITE;
                    end else if ((r_poll_cnt == '0) && (|r_active)) begin
                        r_ch           <= w_poll_ch;
                        r_avmm_read    <= 1'b1;
                        r_avmm_address <= 3'(w_poll_ch);
                        r_poll_cnt     <= c_POLL_RELOAD;
                        r_state        <= ST_READ;
                    end
                end
                ST_WRITE: begin
                    r_active[r_ch]  <= ~r_wr_cancel;
                    r_expired[r_ch] <= 1'b0;
                    r_state         <= ST_IDLE;
                end
                ST_READ: begin
                    if (w_rd_zero && !w_rd_stale) begin
                        r_active[r_ch]  <= 1'b0;
                        r_expired[r_ch] <= 1'b1;
                    end
                    r_rr    <= w_rr_next;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase

            // Request capture runs last so it overrides the clears above.
            for (int i = 0; i < NUM_CH; i++) begin
                if (arm[i]) begin
                    r_arm_pend[i]                           <= 1'b1;
                    r_val[i*TIMER_WIDTH +: TIMER_WIDTH]     <= arm_value[i*TIMER_WIDTH +: TIMER_WIDTH];
                end
                if (cancel[i]) begin
                    r_cancel_pend[i] <= 1'b1;
                    r_arm_pend[i]    <= 1'b0;
                end
            end
        end
    end

    assign active         = r_active;
    assign expired        = r_expired;
    assign avmm_address   = r_avmm_address;
    assign avmm_read      = r_avmm_read;
    assign avmm_write     = r_avmm_write;
    assign avmm_writedata = r_avmm_writedata;

endmodule
`default_nettype wire

// File: tb/tb_timer_watchdog_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_timer_watchdog_ctrl
//  Brief    : Scoreboard bench for timer_watchdog_ctrl with a simple bank model.
//  Revision : 1.0
// ============================================================================
module tb_timer_watchdog_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [2:0]  arm = '0;
    logic [2:0]  cancel = '0;
    logic [59:0] arm_value = '0;
    logic [2:0]  active;
    logic [2:0]  expired;
    logic [2:0]  avmm_address;
    logic        avmm_read;
    logic        avmm_write;
    logic [31:0] avmm_writedata;
    logic [31:0] avmm_readdata;

    logic [19:0] bank [0:7];

    typedef struct packed {
        logic [2:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t        exp_wr[$];
    logic [2:0] exp_rd[$];
    wr_t        mon_e;
    logic [2:0] mon_a;
    int         n_tests = 0;
    int         n_fail = 0;
    int         n_strobes = 0;
    logic       prev_strobe = 1'b0;

    timer_watchdog_ctrl #(
        .NUM_CH        (3),
        .TIMER_WIDTH   (20),
        .POLL_INTERVAL (64)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .arm            (arm),
        .arm_value      (arm_value),
        .cancel         (cancel),
        .active         (active),
        .expired        (expired),
        .avmm_address   (avmm_address),
        .avmm_read      (avmm_read),
        .avmm_write     (avmm_write),
        .avmm_writedata (avmm_writedata),
        .avmm_readdata  (avmm_readdata)
    );

    always #5 clk = ~clk;

    assign avmm_readdata = avmm_read ? {12'h000, bank[avmm_address]} : 32'hDEAD_BEEF;

    // Monitor: pops expectations whenever the DUT presents a strobe.
    always @(negedge clk) begin
        if (!resetn) begin
            prev_strobe = 1'b0;
        end else begin
            if (avmm_write) begin
                n_strobes++;
                n_tests++;
                if (exp_wr.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_write: got addr=%0d data=%h, required no write",
                             avmm_address, avmm_writedata);
                end else begin
                    mon_e = exp_wr.pop_front();
                    if (avmm_address !== mon_e.addr || avmm_writedata !== mon_e.data) begin
                        n_fail++;
                        $display("FAIL write: got addr=%0d data=%h, required addr=%0d data=%h",
                                 avmm_address, avmm_writedata, mon_e.addr, mon_e.data);
                    end
                end
            end
            if (avmm_read) begin
                n_strobes++;
                if (exp_rd.size() != 0) begin
                    mon_a = exp_rd.pop_front();
                    n_tests++;
                    if (avmm_address !== mon_a) begin
                        n_fail++;
                        $display("FAIL read_addr: got %0d, required %0d", avmm_address, mon_a);
                    end
                end
            end
            n_tests++;
            if (avmm_read || avmm_write) begin
                if ((avmm_read && avmm_write) || prev_strobe) begin
                    n_fail++;
                    $display("FAIL strobe_spacing: got rd=%0b wr=%0b prev=%0b, required single isolated strobe",
                             avmm_read, avmm_write, prev_strobe);
                end
            end else if (avmm_writedata !== 32'h0) begin
                n_fail++;
                $display("FAIL idle_writedata: got %h, required 0", avmm_writedata);
            end
            prev_strobe = avmm_read | avmm_write;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Caller sits at a negedge; the pulse is seen by exactly one posedge.
    task automatic pulse(input logic [2:0] a, input logic [2:0] c);
        arm    = a;
        cancel = c;
        @(negedge clk);
        arm    = '0;
        cancel = '0;
    endtask

    task automatic wait_wr_done(input string name, input int budget);
        int i;
        i = 0;
        while (exp_wr.size() != 0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        n_tests++;
        if (exp_wr.size() != 0) begin
            n_fail++;
            $display("FAIL %s: got %0d writes outstanding, required 0", name, exp_wr.size());
            exp_wr.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_expired(input string name, input int ch, input int budget);
        int i;
        i = 0;
        while (!expired[ch] && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(name, 32'(expired[ch]), 32'd1);
    endtask

    task automatic wait_read(input string name, input logic [2:0] ch, input int budget);
        int i;
        i = 0;
        while (!(avmm_read && avmm_address == ch) && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(name, 32'(avmm_read && avmm_address == ch), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) bank[i] = '0;

        // Reset held for three cycles, then quiet period.
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_active",    32'(active),         32'h0);
        check("rst_expired",   32'(expired),        32'h0);
        check("rst_read",      32'(avmm_read),      32'h0);
        check("rst_write",     32'(avmm_write),     32'h0);
        check("rst_address",   32'(avmm_address),   32'h0);
        check("rst_writedata", avmm_writedata,      32'h0);
        resetn    = 1'b1;
        n_strobes = 0;
        repeat (64) @(negedge clk);
        check("quiet_after_reset", 32'(n_strobes), 32'h0);

        // Arm ch1 with 5: write two edges after capture, then an immediate poll.
        arm_value[20 +: 20] = 20'd5;
        bank[1] = 20'd5;
        exp_wr.push_back('{addr: 3'd1, data: 32'h1000_0005});
        exp_rd.push_back(3'd1);
        arm = 3'b010;
        @(negedge clk);
        arm = '0;
        check("arm_latency_edge1", 32'(avmm_write), 32'h0);
        @(negedge clk);
        check("arm_latency_edge2", 32'(avmm_write), 32'h1);
        wait_wr_done("arm1_timeout", 20);
        check("arm1_active",  32'(active),  32'h2);
        check("arm1_expired", 32'(expired), 32'h0);

        // Bank reports zero for ch1 -> sticky expiry; re-arm clears it.
        bank[1] = 20'd0;
        exp_rd.push_back(3'd1);
        wait_expired("exp1_timeout", 1, 200);
        check("exp1_expired", 32'(expired), 32'h2);
        check("exp1_active",  32'(active),  32'h0);
        arm_value[20 +: 20] = 20'd7;
        bank[1] = 20'd7;
        exp_wr.push_back('{addr: 3'd1, data: 32'h1000_0007});
        pulse(3'b010, 3'b000);
        wait_wr_done("rearm1_timeout", 20);
        check("rearm1_expired", 32'(expired), 32'h0);
        check("rearm1_active",  32'(active),  32'h2);

        // arm and cancel of ch0 in one cycle: only the cancel write appears.
        arm_value[0 +: 20] = 20'h00099;
        exp_wr.push_back('{addr: 3'd0, data: 32'h0});
        pulse(3'b001, 3'b001);
        wait_wr_done("armcancel_timeout", 20);
        repeat (4) @(negedge clk);
        check("armcancel_active",  32'(active),  32'h2);
        check("armcancel_expired", 32'(expired), 32'h0);

        // Cancel outranks arm; arms go lowest channel first.
        arm_value[0 +: 20]  = 20'h12345;
        arm_value[40 +: 20] = 20'hABCDE;
        bank[0] = 20'h12345;
        bank[1] = 20'd0;
        bank[2] = 20'hABCDE;
        exp_wr.push_back('{addr: 3'd1, data: 32'h0});
        exp_wr.push_back('{addr: 3'd0, data: 32'h1001_2345});
        exp_wr.push_back('{addr: 3'd2, data: 32'h100A_BCDE});
        pulse(3'b101, 3'b010);
        wait_wr_done("order_timeout", 60);
        check("order_active",  32'(active),  32'h5);
        check("order_expired", 32'(expired), 32'h0);

        // Cancel arriving during the ch2 poll that returns zero: no expiry.
        wait_read("poll2_timeout", 3'd2, 300);
        bank[2] = 20'd0;
        exp_wr.push_back('{addr: 3'd2, data: 32'h0});
        pulse(3'b000, 3'b100);
        wait_wr_done("stale_timeout", 20);
        check("stale_expired", 32'(expired), 32'h0);
        check("stale_active",  32'(active),  32'h1);

        // Zero start count still writes run=1 and expires on the first poll.
        arm_value[0 +: 20] = 20'd0;
        bank[0] = 20'd0;
        exp_wr.push_back('{addr: 3'd0, data: 32'h1000_0000});
        pulse(3'b001, 3'b000);
        wait_wr_done("zero_timeout", 20);
        wait_expired("zero_exp_timeout", 0, 200);
        check("zero_expired", 32'(expired), 32'h1);
        check("zero_active",  32'(active),  32'h0);

        check("reads_drained", 32'(exp_rd.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
